// File: rtl/phy_mgmt_pkg.sv
// Shared definitions for the PHY management controller: state/source encodings,
// PHY status register layout and the power-up configuration table.
package phy_mgmt_pkg;

    typedef enum logic [2:0] {
        ST_INIT_WAIT,
        ST_IDLE,
        ST_ISSUE,
        ST_BUSY,
        ST_DONE
    } state_e;

    typedef enum logic [1:0] {
        SRC_CFG,
        SRC_HOST,
        SRC_POLL
    } src_e;

    typedef struct packed {
        logic [4:0]  addr;
        logic [15:0] data;
    } cfg_entry_t;

    localparam logic [4:0] PHY_STATUS_REG = 5'h11;

    localparam int STS_SPEED_HI = 15;
    localparam int STS_SPEED_LO = 14;
    localparam int STS_DUPLEX   = 13;
    localparam int STS_RESOLVED = 11;
    localparam int STS_LINK     = 10;

    localparam int CFG_LEN   = 3;
    localparam int CFG_IDX_W = $clog2(CFG_LEN) + 1;

    // Drop 1000BASE-T advertisement, advertise 10/100 full/half, restart autoneg.
    function automatic cfg_entry_t cfg_entry(input logic [CFG_IDX_W-1:0] idx);
        cfg_entry_t e;
        case (idx)
            CFG_IDX_W'(0): e = '{addr: 5'd9, data: 16'h0000};
            CFG_IDX_W'(1): e = '{addr: 5'd4, data: 16'h01E1};
            CFG_IDX_W'(2): e = '{addr: 5'd0, data: 16'h1200};
            default:       e = '{addr: 5'd0, data: 16'h0000};
        endcase
        return e;
    endfunction

endpackage

// File: rtl/phy_mgmt_ctrl.sv
// Sequences the MDIO engine: power-up config writes, host register accesses and
// periodic PHY status polling, with a per-transaction timeout.
module phy_mgmt_ctrl
    import phy_mgmt_pkg::*;
#(
    parameter logic [19:0] INIT_DELAY  = 20'd250_000,
    parameter logic [19:0] POLL_PERIOD = 20'd25_000,
    parameter logic [9:0]  TIMEOUT     = 10'd256
) (
    input  logic        clk_i,
    input  logic        srst_i,
    input  logic        host_rd_req_i,
    input  logic        host_wr_req_i,
    input  logic [4:0]  host_addr_i,
    input  logic [15:0] host_wr_data_i,
    output logic        host_busy_o,
    output logic        host_done_o,
    output logic [15:0] host_rd_data_o,
    output logic        link_up_o,
    output logic [1:0]  speed_o,
    output logic        full_duplex_o,
    output logic        status_valid_o,
    output logic        mdio_err_o,
    output logic [4:0]  mdio_addr_o,
    output logic [15:0] mdio_wr_data_o,
    output logic        mdio_rd_request_o,
    output logic        mdio_wr_request_o,
    input  logic        mdio_ready_i,
    input  logic [15:0] mdio_rd_data_i
);

    state_e                 state_q;
    src_e                   src_q;
    logic                   dir_wr_q;
    logic [CFG_IDX_W-1:0]   cfg_idx_q;
    logic [19:0]            init_cnt_q;
    logic [19:0]            poll_cnt_q;
    logic [9:0]             to_cnt_q;
    logic                   host_busy_q;
    logic                   host_done_q;
    logic [15:0]            host_rd_data_q;
    logic                   link_up_q;
    logic [1:0]             speed_q;
    logic                   full_duplex_q;
    logic                   status_valid_q;
    logic                   mdio_err_q;
    logic [4:0]             mdio_addr_q;
    logic [15:0]            mdio_wr_data_q;
    logic                   mdio_rd_req_q;
    logic                   mdio_wr_req_q;

    cfg_entry_t             cfg_cur;
    logic                   cfg_pending;
    logic                   cfg_last;
    logic                   host_pending;
    logic                   poll_due;
    logic                   timeout_hit;
    logic                   req_active;

    always_comb begin
        cfg_cur      = cfg_entry(cfg_idx_q);
        cfg_pending  = (cfg_idx_q < CFG_IDX_W'(CFG_LEN));
        cfg_last     = (cfg_idx_q == CFG_IDX_W'(CFG_LEN - 1));
        host_pending = !host_busy_q && (host_rd_req_i || host_wr_req_i);
        poll_due     = (poll_cnt_q >= POLL_PERIOD);
        timeout_hit  = (to_cnt_q == TIMEOUT - 10'd1);
        req_active   = mdio_rd_req_q || mdio_wr_req_q;
    end

    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            state_q        <= ST_INIT_WAIT;
            src_q          <= SRC_CFG;
            dir_wr_q       <= 1'b0;
            cfg_idx_q      <= '0;
            init_cnt_q     <= '0;
            poll_cnt_q     <= '0;
            to_cnt_q       <= '0;
            host_busy_q    <= 1'b1;
            host_done_q    <= 1'b0;
            host_rd_data_q <= '0;
            link_up_q      <= 1'b0;
            speed_q        <= '0;
            full_duplex_q  <= 1'b0;
            status_valid_q <= 1'b0;
            mdio_err_q     <= 1'b0;
            mdio_addr_q    <= '0;
            mdio_wr_data_q <= '0;
            mdio_rd_req_q  <= 1'b0;
            mdio_wr_req_q  <= 1'b0;
        end else begin
            host_done_q <= 1'b0;
            // host_busy falls the cycle after the host_done pulse.
            if (host_done_q) host_busy_q <= 1'b0;
            if (state_q != ST_INIT_WAIT && poll_cnt_q != '1) poll_cnt_q <= poll_cnt_q + 20'd1;

            case (state_q)
                ST_INIT_WAIT: begin
                    if (init_cnt_q >= INIT_DELAY) state_q <= ST_IDLE;
                    else                          init_cnt_q <= init_cnt_q + 20'd1;
                end

                ST_IDLE: begin
                    to_cnt_q <= '0;
                    if (cfg_pending) begin
                        src_q          <= SRC_CFG;
                        dir_wr_q       <= 1'b1;
                        mdio_addr_q    <= cfg_cur.addr;
                        mdio_wr_data_q <= cfg_cur.data;
                        state_q        <= ST_ISSUE;
                    end else if (host_pending) begin
                        src_q          <= SRC_HOST;
                        dir_wr_q       <= host_wr_req_i;
                        mdio_addr_q    <= host_addr_i;
                        mdio_wr_data_q <= host_wr_data_i;
                        host_busy_q    <= 1'b1;
                        state_q        <= ST_ISSUE;
                    end else if (poll_due) begin
                        src_q          <= SRC_POLL;
                        dir_wr_q       <= 1'b0;
                        mdio_addr_q    <= PHY_STATUS_REG;
                        state_q        <= ST_ISSUE;
                    end
                end

                ST_ISSUE, ST_BUSY: begin
                    to_cnt_q <= to_cnt_q + 10'd1;
                    if (state_q == ST_BUSY && mdio_ready_i) begin
                        state_q <= ST_DONE;
                        case (src_q)
                            SRC_CFG: begin
                                cfg_idx_q <= cfg_idx_q + CFG_IDX_W'(1);
                                if (cfg_last) host_busy_q <= 1'b0;
                            end
                            SRC_HOST: begin
                                host_done_q <= 1'b1;
                                if (!dir_wr_q) host_rd_data_q <= mdio_rd_data_i;
                            end
                            default: begin
                                link_up_q      <= mdio_rd_data_i[STS_LINK];
                                speed_q        <= mdio_rd_data_i[STS_SPEED_HI:STS_SPEED_LO];
                                full_duplex_q  <= mdio_rd_data_i[STS_DUPLEX];
                                status_valid_q <= mdio_rd_data_i[STS_RESOLVED];
                                poll_cnt_q     <= '0;
                            end
                        endcase
                    end else if (timeout_hit) begin
                        mdio_rd_req_q <= 1'b0;
                        mdio_wr_req_q <= 1'b0;
                        mdio_err_q    <= 1'b1;
                        state_q       <= ST_IDLE;
                        case (src_q)
                            SRC_CFG: begin
                                cfg_idx_q <= cfg_idx_q + CFG_IDX_W'(1);
                                if (cfg_last) host_busy_q <= 1'b0;
                            end
                            SRC_HOST: begin
                                host_done_q    <= 1'b1;
                                host_rd_data_q <= 16'hFFFF;
                            end
                            default: begin
                                status_valid_q <= 1'b0;
                                poll_cnt_q     <= '0;
                            end
                        endcase
                    end else if (state_q == ST_ISSUE) begin
                        // Only request while the engine is idle; after a reset it may still be
                        // finishing an old frame, so ready low before we requested is ignored.
                        if (mdio_ready_i) begin
                            mdio_wr_req_q <= dir_wr_q;
                            mdio_rd_req_q <= !dir_wr_q;
                        end else begin
                            mdio_wr_req_q <= 1'b0;
                            mdio_rd_req_q <= 1'b0;
                            if (req_active) state_q <= ST_BUSY;
                        end
                    end
                end

                ST_DONE: state_q <= ST_IDLE;

                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign host_busy_o       = host_busy_q;
    assign host_done_o       = host_done_q;
    assign host_rd_data_o    = host_rd_data_q;
    assign link_up_o         = link_up_q;
    assign speed_o           = speed_q;
    assign full_duplex_o     = full_duplex_q;
    assign status_valid_o    = status_valid_q;
    assign mdio_err_o        = mdio_err_q;
    assign mdio_addr_o       = mdio_addr_q;
    assign mdio_wr_data_o    = mdio_wr_data_q;
    assign mdio_rd_request_o = mdio_rd_req_q;
    assign mdio_wr_request_o = mdio_wr_req_q;

endmodule

// File: tb/tb_phy_mgmt_ctrl.sv
// Directed bench for phy_mgmt_ctrl with a behavioural MDIO engine model
// (ready drops one cycle after a request and returns 64 cycles later).
module tb_phy_mgmt_ctrl;

    logic        clk = 1'b0;
    logic        srst = 1'b1;
    logic        host_rd_req = 1'b0;
    logic        host_wr_req = 1'b0;
    logic [4:0]  host_addr = '0;
    logic [15:0] host_wr_data = '0;
    logic        host_busy, host_done, link_up, full_duplex, status_valid, mdio_err;
    logic [15:0] host_rd_data, mdio_wr_data;
    logic [1:0]  speed;
    logic [4:0]  mdio_addr;
    logic        mdio_rd_request, mdio_wr_request;
    logic        mdio_ready = 1'b1;
    logic [15:0] mdio_rd_data = '0;

    int          checks = 0;
    int          failures = 0;

    logic        model_stuck = 1'b0;
    logic [15:0] poll_val = 16'hAC00;
    int          model_cnt = 0;
    int          bad_req = 0;
    int          both_cnt = 0;
    logic [21:0] log_q[$];

    always #5 clk = ~clk;

    phy_mgmt_ctrl #(
        .INIT_DELAY (20'd10),
        .POLL_PERIOD(20'd40),
        .TIMEOUT    (10'd256)
    ) dut (
        .clk_i            (clk),
        .srst_i           (srst),
        .host_rd_req_i    (host_rd_req),
        .host_wr_req_i    (host_wr_req),
        .host_addr_i      (host_addr),
        .host_wr_data_i   (host_wr_data),
        .host_busy_o      (host_busy),
        .host_done_o      (host_done),
        .host_rd_data_o   (host_rd_data),
        .link_up_o        (link_up),
        .speed_o          (speed),
        .full_duplex_o    (full_duplex),
        .status_valid_o   (status_valid),
        .mdio_err_o       (mdio_err),
        .mdio_addr_o      (mdio_addr),
        .mdio_wr_data_o   (mdio_wr_data),
        .mdio_rd_request_o(mdio_rd_request),
        .mdio_wr_request_o(mdio_wr_request),
        .mdio_ready_i     (mdio_ready),
        .mdio_rd_data_i   (mdio_rd_data)
    );

    function automatic logic [15:0] phy_reg(input logic [4:0] a);
        case (a)
            5'h02:   return 16'h0141;
            5'h11:   return poll_val;
            default: return 16'h0000;
        endcase
    endfunction

    // MDIO engine model; no reset, so it finishes a frame across a controller reset.
    always @(negedge clk) begin
        if (mdio_rd_request && mdio_wr_request) both_cnt <= both_cnt + 1;
        if ((mdio_rd_request || mdio_wr_request) && !mdio_ready) bad_req <= bad_req + 1;
        if (model_cnt != 0) begin
            model_cnt <= model_cnt - 1;
            if (model_cnt == 1) mdio_ready <= 1'b1;
        end else if (mdio_ready && !model_stuck && (mdio_rd_request || mdio_wr_request)) begin
            mdio_ready   <= 1'b0;
            model_cnt    <= 64;
            mdio_rd_data <= mdio_wr_request ? 16'h0000 : phy_reg(mdio_addr);
            log_q.push_back({mdio_wr_request, mdio_addr, mdio_wr_request ? mdio_wr_data : 16'h0000});
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic cond(input int sel);
        case (sel)
            0:       return host_busy == 1'b0;
            1:       return host_done == 1'b1;
            2:       return status_valid == 1'b1;
            3:       return status_valid == 1'b0;
            4:       return mdio_ready == 1'b0;
            5:       return host_busy == 1'b1;
            default: return mdio_ready == 1'b1;
        endcase
    endfunction

    task automatic wait_until(input int sel, input int budget, input string tag);
        int w = 0;
        while (!cond(sel) && w < budget) begin
            @(negedge clk);
            w++;
        end
        check(tag, {31'd0, cond(sel)}, 32'd1);
    endtask

    task automatic wait_log(input int n, input string tag);
        int w = 0;
        while (log_q.size() < n && w < 1000) begin
            @(negedge clk);
            w++;
        end
        check(tag, {31'd0, log_q.size() >= n}, 32'd1);
    endtask

    function automatic logic [31:0] log_at(input int i);
        if (i < log_q.size()) return {10'd0, log_q[i]};
        return 32'hDEAD_BEEF;
    endfunction

    initial begin
        #500_000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        int hi;
        int base;
        logic busy_drop;

        // 1: reset state, then three config writes in table order
        repeat (3) @(negedge clk);
        check("rst_host_busy", {31'd0, host_busy}, 32'd1);
        check("rst_outputs", {23'd0, host_done, link_up, speed, full_duplex, status_valid,
                              mdio_err, mdio_rd_request, mdio_wr_request}, 32'd0);
        srst = 1'b0;
        busy_drop = 1'b0;
        w = 0;
        while (log_q.size() < 3 && w < 1000) begin
            @(negedge clk);
            w++;
            if (!host_busy || mdio_rd_request) busy_drop = 1'b1;
        end
        check("cfg_count", log_q.size(), 32'd3);
        check("cfg0", log_at(0), {10'd0, 1'b1, 5'd9, 16'h0000});
        check("cfg1", log_at(1), {10'd0, 1'b1, 5'd4, 16'h01E1});
        check("cfg2", log_at(2), {10'd0, 1'b1, 5'd0, 16'h1200});
        check("cfg_busy_held", {31'd0, busy_drop}, 32'd0);

        // 2: host read of register 2
        wait_until(0, 300, "t2_busy_low");
        host_rd_req = 1'b1;
        host_addr   = 5'd2;
        wait_until(1, 300, "t2_done");
        check("t2_rd_data", {16'd0, host_rd_data}, 32'h0141);
        host_rd_req = 1'b0;
        @(negedge clk);
        check("t2_done_pulse", {31'd0, host_done}, 32'd0);
        check("t2_busy_after", {31'd0, host_busy}, 32'd0);
        check("t2_log", log_at(3), {10'd0, 1'b0, 5'd2, 16'h0000});

        // 3: status poll returning 16'hAC00
        wait_log(5, "t3_poll_arrive");
        check("t3_poll_log", log_at(4), {10'd0, 1'b0, 5'h11, 16'h0000});
        wait_until(2, 200, "t3_status_valid");
        check("t3_link", {31'd0, link_up}, 32'd1);
        check("t3_speed", {30'd0, speed}, 32'd2);
        check("t3_duplex", {31'd0, full_duplex}, 32'd1);

        // 4: host read long enough for the poll to fall due; write then pending with it
        host_rd_req = 1'b1;
        host_addr   = 5'd2;
        wait_until(5, 60, "t4_grant");
        host_wr_req  = 1'b1;
        host_addr    = 5'h1F;
        host_wr_data = 16'h8000;
        wait_until(1, 300, "t4_rd_done");
        check("t4_rd_data", {16'd0, host_rd_data}, 32'h0141);
        @(negedge clk);
        wait_until(1, 300, "t4_wr_done");
        host_rd_req = 1'b0;
        host_wr_req = 1'b0;
        wait_log(8, "t4_poll_arrive");
        check("t4_log_rd", log_at(5), {10'd0, 1'b0, 5'd2, 16'h0000});
        check("t4_log_wr", log_at(6), {10'd0, 1'b1, 5'h1F, 16'h8000});
        check("t4_log_poll", log_at(7), {10'd0, 1'b0, 5'h11, 16'h0000});
        repeat (2) @(negedge clk);
        wait_until(6, 200, "t4_poll_end");
        repeat (3) @(negedge clk);

        // 5: engine never drops ready -> timeout on a host read
        model_stuck = 1'b1;
        poll_val    = 16'h0400;
        host_rd_req = 1'b1;
        host_addr   = 5'd3;
        w  = 0;
        hi = 0;
        do begin
            @(negedge clk);
            w++;
            if (mdio_rd_request) hi++;
        end while (!host_done && w < 600);
        check("t5_done", {31'd0, host_done}, 32'd1);
        check("t5_rd_data", {16'd0, host_rd_data}, 32'hFFFF);
        check("t5_err", {31'd0, mdio_err}, 32'd1);
        check("t5_req_low", {30'd0, mdio_rd_request, mdio_wr_request}, 32'd0);
        check("t5_req_len", {31'd0, hi >= 250 && hi <= 258}, 32'd1);
        host_rd_req = 1'b0;
        model_stuck = 1'b0;
        wait_log(9, "t5_next_arrive");
        check("t5_next_log", log_at(8), {10'd0, 1'b0, 5'h11, 16'h0000});
        wait_until(3, 200, "t5_status_update");
        check("t5_link", {31'd0, link_up}, 32'd1);
        check("t5_speed_duplex", {29'd0, speed, full_duplex}, 32'd0);
        check("t5_err_sticky", {31'd0, mdio_err}, 32'd1);

        // 6: reset while the engine is mid-frame
        wait_until(4, 200, "t6_engine_busy");
        repeat (5) @(negedge clk);
        srst = 1'b1;
        repeat (2) @(negedge clk);
        check("t6_rst_busy", {31'd0, host_busy}, 32'd1);
        check("t6_rst_outputs", {26'd0, link_up, speed, status_valid, mdio_err,
                                 mdio_rd_request || mdio_wr_request}, 32'd0);
        check("t6_engine_still_busy", {31'd0, mdio_ready}, 32'd0);
        srst = 1'b0;
        base = log_q.size();
        wait_log(base + 1, "t6_restart_arrive");
        check("t6_restart_log", log_at(base), {10'd0, 1'b1, 5'd9, 16'h0000});
        check("t6_no_req_while_busy", bad_req, 32'd0);
        check("t6_never_both_req", both_cnt, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
